// File: rtl/instr_loader.sv
// Serial program loader: assembles 9-bit instructions from a MSB-first bit
// stream and writes them to consecutive instruction-memory addresses.
// Handshake: a bit is transferred on a rising edge where bit_valid and
// bit_ready are both high; bit_ready depends only on the state register.
module instr_loader #(
    parameter int D = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D-1:0] word_count,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic         bit_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [8:0]   wr_data,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [8:0]     shreg_q, shreg_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [D-1:0]   addr_q, addr_d;
    logic [D-1:0]   wc_q, wc_d;
    logic [D-1:0]   addr_inc;

    assign addr_inc = addr_q + D'(1);

    // State and datapath registers; reset aborts any load in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            wc_q      <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            wc_q      <= wc_d;
        end
    end

    // Next-state and datapath update; inputs only matter in the state that owns them.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        wc_d      = wc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wc_d      = word_count;
                    addr_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = (word_count != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    shreg_d = {shreg_q[7:0], bit_in};
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        state_d   = WRITE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            WRITE: begin
                addr_d  = addr_inc;
                state_d = (addr_inc == wc_q) ? DONE : SHIFT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes come straight from the state register, so reset forces them low at once.
    assign bit_ready = (state_q == SHIFT);
    assign wr_en     = (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign wr_addr   = addr_q;
    assign wr_data   = shreg_q;
    assign state_dbg = state_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter D, default 12: instruction address width; matches the instruction memory depth of 2**D words of 9 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a program load; sampled only in IDLE.
REQ-005 word_count  input  D  number of 9-bit instructions to load; latched on an accepted start.
REQ-006 bit_in  input  1  serial instruction bit, MSB first.
REQ-007 bit_valid  input  1  bit_in is valid this cycle.
REQ-008 bit_ready  output  1  loader accepts a bit this cycle; a transfer occurs when bit_valid and bit_ready are both high.
REQ-009 wr_en  output  1  instruction-memory write strobe.
REQ-010 wr_addr  output  D  instruction-memory write address.
REQ-011 wr_data  output  9  instruction word to write.
REQ-012 busy  output  1  high from an accepted start until DONE exits; holds the processor's program counter.
REQ-013 done  output  1  one-cycle pulse when the load completes.

Function
REQ-014 The FSM SHALL have four states: IDLE, SHIFT, WRITE and DONE.
REQ-015 IDLE: start=1 SHALL latch word_count and clear the address counter, then go to SHIFT if word_count!=0, or to DONE if word_count==0.
REQ-016 SHIFT: bit_ready SHALL be 1; each transfer SHALL shift bit_in into the LSB of a 9-bit shift register (shreg <= {shreg[7:0], bit_in}) and increment a 4-bit bit counter.
REQ-017 Cycles in SHIFT without bit_valid SHALL leave the shift register and bit counter unchanged; there is no timeout.
REQ-018 On the 9th accepted bit, the FSM SHALL go to WRITE on the next edge and the bit counter SHALL clear to 0.
REQ-019 WRITE lasts exactly one cycle: wr_en=1, wr_addr=address counter, wr_data=assembled word, bit_ready=0.
REQ-020 On leaving WRITE the address counter SHALL increment by 1; the FSM SHALL go to DONE if the incremented count equals the latched word_count, otherwise back to SHIFT.
REQ-021 DONE lasts one cycle: done=1, busy=1; the FSM then returns to IDLE.
REQ-022 Words SHALL be written to addresses 0..word_count-1 in order; the address never wraps because word_count is at most 2**D-1.
REQ-023 start asserted outside IDLE SHALL be ignored, and the latched word_count SHALL NOT change.
REQ-024 bit_valid asserted outside SHIFT SHALL be ignored and no bit is consumed.
REQ-025 Minimum latency from start to done is 10*N+2 cycles for N words with bit_valid held high: 1 start cycle, 9 SHIFT and 1 WRITE cycle per word, and 1 DONE cycle.
REQ-026 wr_en, bit_ready and done SHALL be decoded from the state register only, with no combinational path from inputs.
REQ-027 busy SHALL be 1 in SHIFT, WRITE and DONE, and 0 in IDLE.

Reset
REQ-028 While reset=1, state SHALL be IDLE, and wr_en, bit_ready, busy and done SHALL be 0 immediately, without waiting for a clock edge.
REQ-029 Reset SHALL clear the shift register, bit counter, address counter, latched word_count, wr_addr and wr_data to 0.
REQ-030 Reset asserted mid-load SHALL abort the load with no further writes; a fresh start SHALL then be required, and loading restarts at address 0.

Verification
REQ-031 Single word: word_count=1, start, then bits 001111110 with bit_valid=1 -> one wr_en pulse, addr 0, data 9'b001111110; done exactly 11 cycles after start.
REQ-032 Multiple words with gaps: word_count=3, words 9'h07E, 9'h0CC, 9'h1DE, bit_valid low every other cycle -> three writes at addr 0,1,2 with those exact data values, then one done pulse, and bit_ready=0 during each WRITE.
REQ-033 Empty load: word_count=0, start -> no wr_en; done=1 and busy=1 on the cycle after start, then IDLE.
REQ-034 Reset mid-load: word_count=2, reset asserted after 5 bits of the first word -> wr_en, busy and bit_ready go to 0 asynchronously; after a new start, the next write lands at addr 0 containing only post-reset bits.
REQ-035 Ignored inputs: start pulsed during SHIFT with word_count=5 while the original load has word_count=2 -> exactly 2 writes; bit_valid pulses in IDLE/DONE -> shift register unchanged.
